// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file slice.
// Defaults mirror the original 32x32, two-read-port decode-stage file.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int ZERO_IDX   = 0;

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode-stage bus between the pipeline (master) and the register file (slave).
// Read ports are flattened: port k lives in slice k of each vector.
interface regfile_mp_if import regfile_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
);

  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pending;
  logic                     stall;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_pending, stall
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_pending, stall
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register write-pending bits: issue sets, writeback clears.
// When both hit the same register on one edge the set wins (newer producer in flight).
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [(1<<ADDR_W)-1:0]   pend
);

  logic wr_ok;
  logic iss_ok;

  // The hardwired zero register never has a producer in flight.
  assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == ADDR_W'(ZERO_IDX)));
  assign iss_ok = iss_en && !((ZERO_REG != 0) && (iss_addr == ADDR_W'(ZERO_IDX)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      if (wr_ok)  pend[wr_addr]  <= 1'b0;
      if (iss_ok) pend[iss_addr] <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with write-pending hazard stall.
// Define REGFILE_BYPASS_EN to forward a same-cycle writeback to matching read ports.
module regfile_mp import regfile_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input logic          clk,
  input logic          rst_n,
  regfile_mp_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]        mem [DEPTH];
  logic [DEPTH-1:0]         pend;
  logic                     wr_ok;
  logic [NUM_RD*DATA_W-1:0] rd_data_v;
  logic [NUM_RD-1:0]        rd_pend_v;

  assign wr_ok = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == ADDR_W'(ZERO_IDX)));

  // Reset seeds every entry with its own index so a fresh file is easy to recognise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(i);
    end else if (wr_ok) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .iss_en   (bus.iss_en),
    .iss_addr (bus.iss_addr),
    .pend     (pend)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              is_zero;
    logic              byp;

    assign ra      = bus.rd_addr[k*ADDR_W +: ADDR_W];
    assign is_zero = (ZERO_REG != 0) && (ra == ADDR_W'(ZERO_IDX));
`ifdef REGFILE_BYPASS_EN
    assign byp = bus.wr_en && (bus.wr_addr == ra) && !is_zero;
`else
    assign byp = 1'b0;
`endif
    assign rd_data_v[k*DATA_W +: DATA_W] = is_zero ? '0 : (byp ? bus.wr_data : mem[ra]);
    assign rd_pend_v[k] = pend[ra] & ~byp;
  end

  assign bus.rd_data    = rd_data_v;
  assign bus.rd_pending = rd_pend_v;
  assign bus.stall      = |(bus.rd_en & rd_pend_v);

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp with four read ports against an array-based model.
// The model follows REGFILE_BYPASS_EN the same way the design build does.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;

  typedef struct {
    logic [NR-1:0]    rd_en;
    logic [NR*AW-1:0] rd_addr;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             iss_en;
    logic [AW-1:0]    iss_addr;
  } stim_t;

  typedef struct {
    string            name;
    logic [NR*DW-1:0] data;
    logic [NR-1:0]    pend;
    logic             stall;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  bit   done;

  exp_t          exp_q[$];
  logic [DW-1:0] mdl_mem [32];
  bit            mdl_pend [32];

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

  regfile_mp #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NUM_RD   (NR),
    .ZERO_REG (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void modelReset();
    for (int i = 0; i < 32; i++) begin
      mdl_mem[i]  = DW'(i);
      mdl_pend[i] = 1'b0;
    end
  endfunction

  // What a reader should observe this cycle given the stored state and current inputs.
  function automatic exp_t modelRead(stim_t s, string name);
    exp_t e;
    e.name  = name;
    e.data  = '0;
    e.pend  = '0;
    e.stall = 1'b0;
    for (int k = 0; k < NR; k++) begin
      int unsigned a;
      bit hit;
      a   = s.rd_addr[k*AW +: AW];
      hit = 1'b0;
`ifdef REGFILE_BYPASS_EN
      hit = s.wr_en && (s.wr_addr == a) && (a != 0);
`endif
      e.data[k*DW +: DW] = (a == 0) ? '0 : (hit ? s.wr_data : mdl_mem[a]);
      e.pend[k] = mdl_pend[a] && !hit;
      if (s.rd_en[k] && e.pend[k]) e.stall = 1'b1;
    end
    return e;
  endfunction

  function automatic void modelCommit(stim_t s);
    if (s.wr_en && s.wr_addr != 0) begin
      mdl_mem[s.wr_addr]  = s.wr_data;
      mdl_pend[s.wr_addr] = 1'b0;
    end
    if (s.iss_en && s.iss_addr != 0) mdl_pend[s.iss_addr] = 1'b1;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rd_en    = '0;
    s.rd_addr  = '0;
    s.wr_en    = 1'b0;
    s.wr_addr  = '0;
    s.wr_data  = '0;
    s.iss_en   = 1'b0;
    s.iss_addr = '0;
    return s;
  endfunction

  function automatic stim_t readAll(reg_idx_t a, logic [NR-1:0] en);
    stim_t s;
    s = idle();
    s.rd_en = en;
    for (int k = 0; k < NR; k++) s.rd_addr[k*AW +: AW] = a;
    return s;
  endfunction

  task automatic driveBus(stim_t s);
    bus.rd_en    = s.rd_en;
    bus.rd_addr  = s.rd_addr;
    bus.wr_en    = s.wr_en;
    bus.wr_addr  = s.wr_addr;
    bus.wr_data  = s.wr_data;
    bus.iss_en   = s.iss_en;
    bus.iss_addr = s.iss_addr;
  endtask

  // Called at posedge+1: drive, queue the expectation, then commit on the next edge.
  task automatic applyStimulus(stim_t s, string name);
    driveBus(s);
    exp_q.push_back(modelRead(s, name));
    @(posedge clk);
    modelCommit(s);
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle; held across one edge, released at posedge+1.
  task automatic applyReset(stim_t s, string name);
    driveBus(s);
    rst_n = 1'b0;
    modelReset();
    #1;
    exp_q.push_back(modelRead(s, name));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic checkOutput(exp_t e);
    total++;
    if (bus.rd_data !== e.data) begin
      bad++;
      $display("[TB] FAIL %s rd_data got=%h want=%h", e.name, bus.rd_data, e.data);
    end
    total++;
    if (bus.rd_pending !== e.pend) begin
      bad++;
      $display("[TB] FAIL %s rd_pending got=%b want=%b", e.name, bus.rd_pending, e.pend);
    end
    total++;
    if (bus.stall !== e.stall) begin
      bad++;
      $display("[TB] FAIL %s stall got=%b want=%b", e.name, bus.stall, e.stall);
    end
  endtask

  // Monitor: the outputs are presented every cycle, so pop one expectation per negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    if (!done) begin
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] timeout");
    end
  end

  initial begin
    stim_t s;
    total = 0;
    bad   = 0;
    done  = 1'b0;
    rst_n = 1'b0;
    modelReset();
    driveBus(idle());
    @(posedge clk);
    #1;

    s = idle();
    s.rd_addr[0*AW +: AW] = 5'd7;
    s.rd_addr[1*AW +: AW] = 5'd31;
    s.rd_addr[2*AW +: AW] = 5'd0;
    s.rd_addr[3*AW +: AW] = 5'd3;
    applyReset(s, "reset_state");
    applyStimulus(s, "after_reset");

    s = readAll(5'd5, '0);
    s.wr_en = 1'b1; s.wr_addr = 5'd5; s.wr_data = 32'hDEADBEEF;
    applyStimulus(s, "wr5_cycle");
    applyStimulus(readAll(5'd5, '0), "wr5_next");

    s = readAll(5'd0, '0);
    s.wr_en = 1'b1; s.wr_addr = 5'd0; s.wr_data = 32'h1234;
    applyStimulus(s, "wr0_cycle");
    applyStimulus(readAll(5'd0, '0), "wr0_next");

    s = readAll(5'd9, 4'b0001);
    s.iss_en = 1'b1; s.iss_addr = 5'd9;
    applyStimulus(s, "iss9_cycle");
    applyStimulus(readAll(5'd9, 4'b0001), "iss9_pending");
    s = readAll(5'd9, 4'b0001);
    s.wr_en = 1'b1; s.wr_addr = 5'd9; s.wr_data = 32'h55;
    applyStimulus(s, "wr9_cycle");
    applyStimulus(readAll(5'd9, 4'b0001), "wr9_next");

    s = readAll(5'd12, '0);
    s.wr_en = 1'b1; s.wr_addr = 5'd12; s.wr_data = 32'hA;
    s.iss_en = 1'b1; s.iss_addr = 5'd12;
    applyStimulus(s, "iss_wr12");
    applyStimulus(readAll(5'd12, 4'b1111), "iss_wr12_next");

    s = idle();
    s.iss_en = 1'b1; s.iss_addr = 5'd3;
    applyStimulus(s, "iss3");
    applyStimulus(readAll(5'd3, 4'b0100), "all3_en2");
    applyStimulus(readAll(5'd3, 4'b0000), "all3_noen");

    s = idle();
    s.iss_en = 1'b1; s.iss_addr = 5'd0;
    applyStimulus(s, "iss0");
    applyStimulus(readAll(5'd0, 4'b1111), "iss0_next");

    s = idle();
    s.iss_en = 1'b1; s.iss_addr = 5'd20;
    applyStimulus(s, "iss20");
    applyStimulus(readAll(5'd20, 4'b1111), "iss20_pending");
    applyReset(readAll(5'd20, 4'b1111), "reset_mid");
    applyStimulus(readAll(5'd20, 4'b1111), "reset_mid_after");

    for (int n = 0; n < 400; n++) begin
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      s = idle();
      s.rd_en = NR'($urandom);
      for (int k = 0; k < NR; k++)
        s.rd_addr[k*AW +: AW] = narrow ? AW'($urandom_range(0, 5)) : AW'($urandom);
      s.wr_en    = ($urandom_range(0, 2) == 0);
      s.wr_addr  = narrow ? AW'($urandom_range(0, 5)) : AW'($urandom);
      s.wr_data  = $urandom;
      s.iss_en   = ($urandom_range(0, 2) == 0);
      s.iss_addr = narrow ? AW'($urandom_range(0, 5)) : AW'($urandom);
      if (n == 200) applyReset(s, "rand_reset");
      else applyStimulus(s, "random");
    end

    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain pending got=%0d want=0", exp_q.size());
    end
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
